ysyx_22050550_wbu_arb: RTL and testbench

YSYX_22050550_WBU_ARB -- requirements
Module: ysyx_22050550_wbu_arb

---
 rtl/ysyx_22050550_define.sv | 19 +
 rtl/ysyx_22050550_wbu_arb_if.sv | 12 +
 rtl/ysyx_22050550_wb_rr_arb.sv | 40 ++++
 rtl/ysyx_22050550_wbu_arb.sv | 87 ++++++++
 tb/tb_ysyx_22050550_wbu_arb.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22050550_define.sv
// Shared write-back widths and requester encoding.
package ysyx_22050550_define;

  localparam int XLEN    = 64;
  localparam int REG_NUM = 32;
  localparam int REG_AW  = $clog2(REG_NUM);

  typedef enum logic {
    REQ_EXU = 1'b0,
    REQ_LSU = 1'b1
  } req_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] waddr;
    logic [XLEN-1:0]   wdata;
  } wb_t;

endpackage

// File: rtl/ysyx_22050550_wbu_arb_if.sv
// Valid/ready pairs between the write-back top and its arbiter.
interface ysyx_22050550_wbu_arb_if;

  logic exu_valid;
  logic exu_ready;
  logic lsu_valid;
  logic lsu_ready;

  modport arb (input exu_valid, lsu_valid, output exu_ready, lsu_ready);
  modport req (output exu_valid, lsu_valid, input exu_ready, lsu_ready);

endinterface

// File: rtl/ysyx_22050550_wb_rr_arb.sv
// Two-way write-back arbiter: fixed LSU priority, or round-robin on conflicts
// when YSYX_22050550_WB_RR_EN is defined.
module ysyx_22050550_wb_rr_arb
  import ysyx_22050550_define::*;
(
`ifdef YSYX_22050550_WB_RR_EN
  input logic                  clk,
`endif
  input logic                  rst,
  ysyx_22050550_wbu_arb_if.arb bus
);

  req_e grant;

`ifdef YSYX_22050550_WB_RR_EN
  req_e last_q, last_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= REQ_LSU;
    else     last_q <= last_d;
  end

  // Only an actual transfer moves the round-robin pointer.
  always_comb begin
    last_d = last_q;
    if (bus.exu_ready || bus.lsu_ready) last_d = grant;
  end
`endif

  always_comb begin
    grant = bus.lsu_valid ? REQ_LSU : REQ_EXU;
`ifdef YSYX_22050550_WB_RR_EN
    if (bus.lsu_valid && bus.exu_valid)
      grant = (last_q == REQ_LSU) ? REQ_EXU : REQ_LSU;
`endif
    bus.lsu_ready = !rst && bus.lsu_valid && (grant == REQ_LSU);
    bus.exu_ready = !rst && bus.exu_valid && (grant == REQ_EXU);
  end

endmodule

// File: rtl/ysyx_22050550_wbu_arb.sv
// Write-back unit: arbitrates EXU/LSU results into one registered write port
// and keeps the register busy scoreboard. Optional macro: YSYX_22050550_WB_RR_EN.
module ysyx_22050550_wbu_arb
  import ysyx_22050550_define::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              io_ISS_valid,
  input  logic              io_ISS_wen,
  input  logic [REG_AW-1:0] io_ISS_waddr,
  input  logic              io_EXU_valid,
  output logic              io_EXU_ready,
  input  logic [REG_AW-1:0] io_EXU_waddr,
  input  logic [XLEN-1:0]   io_EXU_wdata,
  input  logic              io_LSU_valid,
  output logic              io_LSU_ready,
  input  logic [REG_AW-1:0] io_LSU_waddr,
  input  logic [XLEN-1:0]   io_LSU_wdata,
  output logic              io_WBU_valid,
  output logic [REG_AW-1:0] io_WBU_waddr,
  output logic [XLEN-1:0]   io_WBU_rdata,
  input  logic [REG_AW-1:0] io_IDU_raddr1,
  input  logic [REG_AW-1:0] io_IDU_raddr2,
  output logic              io_IDU_busy1,
  output logic              io_IDU_busy2
);

  ysyx_22050550_wbu_arb_if arb_bus ();

  assign arb_bus.exu_valid = io_EXU_valid;
  assign arb_bus.lsu_valid = io_LSU_valid;
  assign io_EXU_ready      = arb_bus.exu_ready;
  assign io_LSU_ready      = arb_bus.lsu_ready;

  ysyx_22050550_wb_rr_arb u_arb (
`ifdef YSYX_22050550_WB_RR_EN
    .clk (clock),
`endif
    .rst (reset),
    .bus (arb_bus.arb)
  );

  wb_t               wb_q, wb_d;
  logic [REG_NUM-1:0] busy_q, busy_d;

  // Writes to x0 are consumed but never presented as valid.
  always_comb begin
    wb_d.valid = 1'b0;
    wb_d.waddr = wb_q.waddr;
    wb_d.wdata = wb_q.wdata;
    if (arb_bus.lsu_ready) begin
      wb_d.valid = (io_LSU_waddr != '0);
      wb_d.waddr = io_LSU_waddr;
      wb_d.wdata = io_LSU_wdata;
    end else if (arb_bus.exu_ready) begin
      wb_d.valid = (io_EXU_waddr != '0);
      wb_d.waddr = io_EXU_waddr;
      wb_d.wdata = io_EXU_wdata;
    end
  end

  // Issue set is applied after the write-back clear so the set wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_q.valid) busy_d[wb_q.waddr] = 1'b0;
    if (io_ISS_valid && io_ISS_wen) busy_d[io_ISS_waddr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_q   <= '0;
      busy_q <= '0;
    end else begin
      wb_q   <= wb_d;
      busy_q <= busy_d;
    end
  end

  assign io_WBU_valid = wb_q.valid;
  assign io_WBU_waddr = wb_q.waddr;
  assign io_WBU_rdata = wb_q.wdata;

  assign io_IDU_busy1 = busy_q[io_IDU_raddr1] && !(wb_q.valid && (wb_q.waddr == io_IDU_raddr1));
  assign io_IDU_busy2 = busy_q[io_IDU_raddr2] && !(wb_q.valid && (wb_q.waddr == io_IDU_raddr2));

endmodule

// File: tb/tb_ysyx_22050550_wbu_arb.sv
// Bench for ysyx_22050550_wbu_arb: directed table, corner sequences, random vs model.
module tb_ysyx_22050550_wbu_arb;
  import ysyx_22050550_define::*;

  logic        clock;
  logic        reset;
  logic        iss_v, iss_wen;
  logic [4:0]  iss_wa, exu_wa, lsu_wa, ra1, ra2, wbu_wa;
  logic [63:0] exu_wd, lsu_wd, wbu_wd;
  logic        wbu_v, busy1, busy2;

  int total = 0;
  int bad   = 0;

  ysyx_22050550_wbu_arb_if tb_if ();

  ysyx_22050550_wbu_arb dut (
    .clock         (clock),
    .reset         (reset),
    .io_ISS_valid  (iss_v),
    .io_ISS_wen    (iss_wen),
    .io_ISS_waddr  (iss_wa),
    .io_EXU_valid  (tb_if.exu_valid),
    .io_EXU_ready  (tb_if.exu_ready),
    .io_EXU_waddr  (exu_wa),
    .io_EXU_wdata  (exu_wd),
    .io_LSU_valid  (tb_if.lsu_valid),
    .io_LSU_ready  (tb_if.lsu_ready),
    .io_LSU_waddr  (lsu_wa),
    .io_LSU_wdata  (lsu_wd),
    .io_WBU_valid  (wbu_v),
    .io_WBU_waddr  (wbu_wa),
    .io_WBU_rdata  (wbu_wd),
    .io_IDU_raddr1 (ra1),
    .io_IDU_raddr2 (ra2),
    .io_IDU_busy1  (busy1),
    .io_IDU_busy2  (busy2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic iw, input logic [4:0] ia,
                       input logic ev, input logic [4:0] ea, input logic [63:0] ed,
                       input logic lv, input logic [4:0] la, input logic [63:0] ld,
                       input logic [4:0] r1, input logic [4:0] r2);
    iss_v = iv; iss_wen = iw; iss_wa = ia;
    tb_if.exu_valid = ev; exu_wa = ea; exu_wd = ed;
    tb_if.lsu_valid = lv; lsu_wa = la; lsu_wd = ld;
    ra1 = r1; ra2 = r2;
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    drive(0, 0, 0, 0, 0, 64'h0, 0, 0, 64'h0, r1, r2);
  endtask

  // Leaves the bench at posedge+1 with reset released.
  task automatic do_reset();
    reset = 1'b1;
    idle(0, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  // Reference model: registered write-back slot, busy set, round-robin memory.
  bit          m_wv;
  bit [4:0]    m_wa;
  bit [63:0]   m_wd;
  bit          m_busy[32];
  int          m_last;

  task automatic model_init();
    m_wv = 0; m_wa = 0; m_wd = 0; m_last = 1;
    for (int i = 0; i < 32; i++) m_busy[i] = 0;
  endtask

  // -1 nobody, 0 EXU, 1 LSU
  function automatic int winner();
    if (!tb_if.exu_valid && !tb_if.lsu_valid) return -1;
    if (!tb_if.lsu_valid) return 0;
    if (!tb_if.exu_valid) return 1;
`ifdef YSYX_22050550_WB_RR_EN
    return 1 - m_last;
`else
    return 1;
`endif
  endfunction

  task automatic model_check();
    int  w;
    bit  b1, b2;
    w  = winner();
    b1 = m_busy[ra1] && !(m_wv && m_wa == ra1);
    b2 = m_busy[ra2] && !(m_wv && m_wa == ra2);
    chk("rnd_exu_ready", 64'(tb_if.exu_ready), 64'(w == 0));
    chk("rnd_lsu_ready", 64'(tb_if.lsu_ready), 64'(w == 1));
    chk("rnd_wbu_valid", 64'(wbu_v), 64'(m_wv));
    if (m_wv) begin
      chk("rnd_wbu_waddr", 64'(wbu_wa), 64'(m_wa));
      chk("rnd_wbu_rdata", wbu_wd, m_wd);
    end
    chk("rnd_busy1", 64'(busy1), 64'(b1));
    chk("rnd_busy2", 64'(busy2), 64'(b2));
  endtask

  task automatic model_advance(input int w);
    if (m_wv) m_busy[m_wa] = 0;
    if (iss_v && iss_wen && iss_wa != 0) m_busy[iss_wa] = 1;
    if (w < 0) begin
      m_wv = 0;
    end else begin
      m_wa   = (w == 1) ? lsu_wa : exu_wa;
      m_wd   = (w == 1) ? lsu_wd : exu_wd;
      m_wv   = (m_wa != 0);
      m_last = w;
    end
  endtask

  typedef struct {
    int          iv, iw, ia;
    int          ev, ea;
    logic [63:0] ed;
    int          lv, la;
    logic [63:0] ld;
    int          r1, r2;
    int          x_er, x_lr, x_wv, x_wa;
    logic [63:0] x_wd;
    int          x_b1, x_b2;
  } vec_t;

  vec_t tbl[$];

  logic        e_v, l_v;
  logic [4:0]  e_a, l_a;
  logic [63:0] e_d, l_d;

  initial begin
    // Directed per-cycle vectors from a fresh reset; expected values seen in that cycle.
    tbl.push_back(vec_t'{0,0,0, 1,5,64'h1234, 0,0,64'h0, 5,0, 1,0,0,0,64'h0,    0,0});
    tbl.push_back(vec_t'{0,0,0, 0,0,64'h0,    0,0,64'h0, 5,0, 0,0,1,5,64'h1234, 0,0});
    tbl.push_back(vec_t'{0,0,0, 0,0,64'h0,    0,0,64'h0, 5,0, 0,0,0,0,64'h0,    0,0});
    tbl.push_back(vec_t'{1,1,7, 0,0,64'h0,    0,0,64'h0, 7,0, 0,0,0,0,64'h0,    0,0});
    tbl.push_back(vec_t'{0,0,0, 0,0,64'h0,    0,0,64'h0, 7,0, 0,0,0,0,64'h0,    1,0});
    tbl.push_back(vec_t'{0,0,0, 1,7,64'h77,   0,0,64'h0, 7,0, 1,0,0,0,64'h0,    1,0});
    tbl.push_back(vec_t'{0,0,0, 0,0,64'h0,    0,0,64'h0, 7,0, 0,0,1,7,64'h77,   0,0});
    tbl.push_back(vec_t'{0,0,0, 0,0,64'h0,    0,0,64'h0, 7,0, 0,0,0,0,64'h0,    0,0});
    tbl.push_back(vec_t'{1,1,9, 0,0,64'h0,    0,0,64'h0, 0,9, 0,0,0,0,64'h0,    0,0});
    tbl.push_back(vec_t'{0,0,0, 1,9,64'h99,   0,0,64'h0, 0,9, 1,0,0,0,64'h0,    0,1});
    tbl.push_back(vec_t'{1,1,9, 0,0,64'h0,    0,0,64'h0, 0,9, 0,0,1,9,64'h99,   0,0});
    tbl.push_back(vec_t'{0,0,0, 0,0,64'h0,    0,0,64'h0, 0,9, 0,0,0,0,64'h0,    0,1});
    tbl.push_back(vec_t'{0,0,0, 1,9,64'h9a,   0,0,64'h0, 0,9, 1,0,0,0,64'h0,    0,1});
    tbl.push_back(vec_t'{0,0,0, 0,0,64'h0,    0,0,64'h0, 0,9, 0,0,1,9,64'h9a,   0,0});
    tbl.push_back(vec_t'{0,0,0, 0,0,64'h0,    0,0,64'h0, 0,9, 0,0,0,0,64'h0,    0,0});
    tbl.push_back(vec_t'{1,1,0, 0,0,64'h0,    0,0,64'h0, 0,0, 0,0,0,0,64'h0,    0,0});
    tbl.push_back(vec_t'{0,0,0, 0,0,64'h0,    1,0,64'h55, 0,0, 0,1,0,0,64'h0,   0,0});
    tbl.push_back(vec_t'{0,0,0, 0,0,64'h0,    0,0,64'h0, 0,0, 0,0,0,0,64'h0,    0,0});
    tbl.push_back(vec_t'{0,0,0, 0,0,64'h0,    1,12,64'hdead, 0,0, 0,1,0,0,64'h0, 0,0});
    tbl.push_back(vec_t'{1,0,3, 0,0,64'h0,    0,0,64'h0, 3,12, 0,0,1,12,64'hdead, 0,0});
    tbl.push_back(vec_t'{0,0,0, 0,0,64'h0,    0,0,64'h0, 3,0, 0,0,0,0,64'h0,    0,0});

    // Reset state, with both requesters asserting valid.
    reset = 1'b1;
    drive(1, 1, 5, 1, 3, 64'h1, 1, 4, 64'h2, 5, 4);
    #12;
    chk("rst_wbu_valid", 64'(wbu_v), 64'h0);
    chk("rst_wbu_waddr", 64'(wbu_wa), 64'h0);
    chk("rst_wbu_rdata", wbu_wd, 64'h0);
    chk("rst_exu_ready", 64'(tb_if.exu_ready), 64'h0);
    chk("rst_lsu_ready", 64'(tb_if.lsu_ready), 64'h0);
    chk("rst_busy1", 64'(busy1), 64'h0);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].iv != 0, tbl[i].iw != 0, 5'(tbl[i].ia),
            tbl[i].ev != 0, 5'(tbl[i].ea), tbl[i].ed,
            tbl[i].lv != 0, 5'(tbl[i].la), tbl[i].ld,
            5'(tbl[i].r1), 5'(tbl[i].r2));
      @(negedge clock);
      chk($sformatf("vec%0d_exu_ready", i), 64'(tb_if.exu_ready), 64'(tbl[i].x_er));
      chk($sformatf("vec%0d_lsu_ready", i), 64'(tb_if.lsu_ready), 64'(tbl[i].x_lr));
      chk($sformatf("vec%0d_wbu_valid", i), 64'(wbu_v), 64'(tbl[i].x_wv));
      if (tbl[i].x_wv != 0) begin
        chk($sformatf("vec%0d_wbu_waddr", i), 64'(wbu_wa), 64'(tbl[i].x_wa));
        chk($sformatf("vec%0d_wbu_rdata", i), wbu_wd, tbl[i].x_wd);
      end
      chk($sformatf("vec%0d_busy1", i), 64'(busy1), 64'(tbl[i].x_b1));
      chk($sformatf("vec%0d_busy2", i), 64'(busy2), 64'(tbl[i].x_b2));
      @(posedge clock);
      #1;
    end

    // Conflict sequences; a loser holds its request until granted.
    do_reset();
`ifdef YSYX_22050550_WB_RR_EN
    drive(0, 0, 0, 1, 1, 64'h1, 0, 0, 64'h0, 0, 0);
    @(posedge clock); #1;
    drive(0, 0, 0, 1, 3, 64'hA, 1, 4, 64'hB, 0, 0);
    @(negedge clock);
    chk("rr0_lsu_ready", 64'(tb_if.lsu_ready), 64'h1);
    chk("rr0_exu_ready", 64'(tb_if.exu_ready), 64'h0);
    @(posedge clock); #1;
    drive(0, 0, 0, 1, 3, 64'hA, 1, 6, 64'hC, 0, 0);
    @(negedge clock);
    chk("rr1_exu_ready", 64'(tb_if.exu_ready), 64'h1);
    chk("rr1_lsu_ready", 64'(tb_if.lsu_ready), 64'h0);
    chk("rr1_wbu_waddr", 64'(wbu_wa), 64'h4);
    chk("rr1_wbu_rdata", wbu_wd, 64'hB);
    @(posedge clock); #1;
    drive(0, 0, 0, 1, 8, 64'hD, 1, 6, 64'hC, 0, 0);
    @(negedge clock);
    chk("rr2_lsu_ready", 64'(tb_if.lsu_ready), 64'h1);
    chk("rr2_exu_ready", 64'(tb_if.exu_ready), 64'h0);
    chk("rr2_wbu_waddr", 64'(wbu_wa), 64'h3);
    chk("rr2_wbu_rdata", wbu_wd, 64'hA);
    @(posedge clock); #1;
    idle(0, 0);
    @(negedge clock);
    chk("rr3_wbu_waddr", 64'(wbu_wa), 64'h6);
    chk("rr3_wbu_rdata", wbu_wd, 64'hC);
    @(posedge clock); #1;
`else
    drive(0, 0, 0, 1, 3, 64'hA, 1, 4, 64'hB, 0, 0);
    @(negedge clock);
    chk("fix0_lsu_ready", 64'(tb_if.lsu_ready), 64'h1);
    chk("fix0_exu_ready", 64'(tb_if.exu_ready), 64'h0);
    @(posedge clock); #1;
    drive(0, 0, 0, 1, 3, 64'hA, 0, 0, 64'h0, 0, 0);
    @(negedge clock);
    chk("fix1_exu_ready", 64'(tb_if.exu_ready), 64'h1);
    chk("fix1_wbu_valid", 64'(wbu_v), 64'h1);
    chk("fix1_wbu_waddr", 64'(wbu_wa), 64'h4);
    chk("fix1_wbu_rdata", wbu_wd, 64'hB);
    @(posedge clock); #1;
    idle(0, 0);
    @(negedge clock);
    chk("fix2_wbu_waddr", 64'(wbu_wa), 64'h3);
    chk("fix2_wbu_rdata", wbu_wd, 64'hA);
    @(posedge clock); #1;
`endif

    // Asynchronous reset while a result is presented and registers are busy.
    do_reset();
    drive(1, 1, 7, 0, 0, 64'h0, 0, 0, 64'h0, 7, 9);
    @(posedge clock); #1;
    drive(1, 1, 9, 1, 7, 64'h70, 0, 0, 64'h0, 7, 9);
    @(posedge clock); #1;
    drive(0, 0, 0, 1, 7, 64'h71, 0, 0, 64'h0, 7, 9);
    #2;
    chk("mid_wbu_valid_pre", 64'(wbu_v), 64'h1);
    chk("mid_busy2_pre", 64'(busy2), 64'h1);
    reset = 1'b1;
    #1;
    chk("mid_wbu_valid", 64'(wbu_v), 64'h0);
    chk("mid_wbu_waddr", 64'(wbu_wa), 64'h0);
    chk("mid_wbu_rdata", wbu_wd, 64'h0);
    chk("mid_exu_ready", 64'(tb_if.exu_ready), 64'h0);
    chk("mid_busy2", 64'(busy2), 64'h0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("post_exu_ready", 64'(tb_if.exu_ready), 64'h1);
    chk("post_busy1", 64'(busy1), 64'h0);
    @(posedge clock); #1;
    idle(7, 9);
    @(negedge clock);
    chk("post_wbu_valid", 64'(wbu_v), 64'h1);
    chk("post_wbu_rdata", wbu_wd, 64'h71);
    @(posedge clock); #1;

    // Random traffic against the model.
    do_reset();
    model_init();
    e_v = 0; l_v = 0; e_a = 0; l_a = 0; e_d = 0; l_d = 0;
    for (int c = 0; c < 600; c++) begin
      int w;
      if (!e_v) begin
        e_v = ($urandom % 2) == 0;
        e_a = 5'($urandom_range(0, 7));
        e_d = {$urandom, $urandom};
      end
      if (!l_v) begin
        l_v = ($urandom % 3) == 0;
        l_a = 5'($urandom_range(0, 7));
        l_d = {$urandom, $urandom};
      end
      drive(($urandom % 2) == 0, ($urandom % 4) != 0, 5'($urandom_range(0, 7)),
            e_v, e_a, e_d, l_v, l_a, l_d,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      @(negedge clock);
      model_check();
      w = winner();
      model_advance(w);
      if (w == 0) e_v = 0;
      if (w == 1) l_v = 0;
      @(posedge clock);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
